// File: rtl/path_cmd_arbiter_pkg.sv
// path_cmd_arbiter_pkg: shared requester and state encodings for the DRAM command arbiters
package path_cmd_arbiter_pkg;
  localparam int NumReq = 3;
  typedef enum logic [1:0] {REQ_RD = 2'd0, REQ_WB = 2'd1, REQ_HD = 2'd2} req_e;
  typedef enum logic {ST_Idle = 1'b0, ST_Lock = 1'b1} state_e;
endpackage

// File: rtl/path_cmd_arbiter_pick.sv
// rr_priority_pick: combinational round-robin picker where any valid overridden requester beats plain round-robin order
module rr_priority_pick
  import path_cmd_arbiter_pkg::*;
(
  input  logic [NumReq-1:0] Valid,
  input  logic [1:0]        Ptr,
  input  logic [NumReq-1:0] Override,
  output logic [NumReq-1:0] Pick
);
  logic [NumReq-1:0] ovr;
  logic [1:0] idx;
  assign ovr = Valid & Override;
  always_comb begin
    Pick = '0;
    idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = 2'((int'(Ptr) + i) % NumReq);
      if (Pick == '0 && (|ovr ? ovr[idx] : Valid[idx])) Pick[idx] = 1'b1;
    end
  end
endmodule

// File: rtl/path_cmd_arbiter.sv
// path_cmd_arbiter: packet-locked round-robin share of the DRAM address/command channel among RD, WB and HD
module path_cmd_arbiter
  import path_cmd_arbiter_pkg::*;
#(
  parameter int DDRAWidth = 28,
  parameter int DDRCWidth = 3,
  parameter int LenWidth  = 10
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DDRAWidth-1:0] RDAddr,
  input  logic [DDRCWidth-1:0] RDCmd,
  input  logic [LenWidth-1:0]  RDLen,
  input  logic                 RDValid,
  output logic                 RDReady,
  input  logic [DDRAWidth-1:0] WBAddr,
  input  logic [DDRCWidth-1:0] WBCmd,
  input  logic [LenWidth-1:0]  WBLen,
  input  logic                 WBValid,
  output logic                 WBReady,
  input  logic [DDRAWidth-1:0] HDAddr,
  input  logic [DDRCWidth-1:0] HDCmd,
  input  logic [LenWidth-1:0]  HDLen,
  input  logic                 HDValid,
  output logic                 HDReady,
  input  logic                 StashAlmostFull,
  output logic [DDRAWidth-1:0] DRAMAddr,
  output logic [DDRCWidth-1:0] DRAMCommand,
  output logic                 DRAMCommandValid,
  input  logic                 DRAMCommandReady,
  output logic [2:0]           Grant,
  output logic                 AddrTransfer,
  output logic                 PacketDone
);
  state_e state_q, state_d;
  req_e rr_ptr_q;
  logic [2:0] grant_q, pick, req_valid;
  logic [LenWidth-1:0] beats_left_q, pick_len;
  logic lock;
  assign req_valid = {HDValid, WBValid, RDValid};
  assign lock = state_q == ST_Lock;
  rr_priority_pick u_pick (
    .Valid(req_valid),
    .Ptr(rr_ptr_q),
    .Override({1'b0, StashAlmostFull, 1'b0}),
    .Pick(pick)
  );
  assign pick_len = pick[0] ? RDLen : pick[1] ? WBLen : HDLen;
  assign DRAMAddr = grant_q[0] ? RDAddr : grant_q[1] ? WBAddr : HDAddr;
  assign DRAMCommand = grant_q[0] ? RDCmd : grant_q[1] ? WBCmd : HDCmd;
  assign DRAMCommandValid = lock & |(grant_q & req_valid);
  assign {HDReady, WBReady, RDReady} = lock ? grant_q & {3{DRAMCommandReady}} : 3'b000;
  assign AddrTransfer = DRAMCommandValid & DRAMCommandReady;
  assign PacketDone = AddrTransfer & (beats_left_q == LenWidth'(1));
  assign Grant = grant_q;
  always_comb begin
    state_d = lock ? (PacketDone ? ST_Idle : ST_Lock) : (|req_valid ? ST_Lock : ST_Idle);
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_Idle;
      grant_q <= '0;
      rr_ptr_q <= REQ_RD;
      beats_left_q <= '0;
    end else begin
      state_q <= state_d;
      if (!lock && |req_valid) begin
        grant_q <= pick;
        beats_left_q <= pick_len == '0 ? LenWidth'(1) : pick_len;
      end else if (AddrTransfer && beats_left_q != '0) beats_left_q <= beats_left_q - LenWidth'(1);
      if (PacketDone) begin
        grant_q <= '0;
        rr_ptr_q <= grant_q[0] ? REQ_WB : grant_q[1] ? REQ_HD : REQ_RD;
      end
    end
  end
`ifdef SIMULATION
  always_ff @(posedge Clock) begin
    if (Reset && !lock && |req_valid && pick_len == '0)
      $display("path_cmd_arbiter: ERROR zero-length packet request, treated as 1 beat");
  end
`endif
endmodule

// File: tb/tb_path_cmd_arbiter.sv
// tb_path_cmd_arbiter: randomized packet-level scoreboard bench for path_cmd_arbiter
module tb_path_cmd_arbiter;
  localparam int AW = 28;
  localparam int CW = 3;
  localparam int LW = 10;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic [AW-1:0] RDAddr, WBAddr, HDAddr, DRAMAddr;
  logic [CW-1:0] RDCmd, WBCmd, HDCmd, DRAMCommand;
  logic [LW-1:0] RDLen, WBLen, HDLen;
  logic RDValid, WBValid, HDValid, RDReady, WBReady, HDReady;
  logic StashAlmostFull, DRAMCommandValid, DRAMCommandReady, AddrTransfer, PacketDone;
  logic [2:0] Grant;
  always #5 Clock = ~Clock;
  path_cmd_arbiter #(.DDRAWidth(AW), .DDRCWidth(CW), .LenWidth(LW)) dut (
    .Clock(Clock), .Reset(Reset),
    .RDAddr(RDAddr), .RDCmd(RDCmd), .RDLen(RDLen), .RDValid(RDValid), .RDReady(RDReady),
    .WBAddr(WBAddr), .WBCmd(WBCmd), .WBLen(WBLen), .WBValid(WBValid), .WBReady(WBReady),
    .HDAddr(HDAddr), .HDCmd(HDCmd), .HDLen(HDLen), .HDValid(HDValid), .HDReady(HDReady),
    .StashAlmostFull(StashAlmostFull),
    .DRAMAddr(DRAMAddr), .DRAMCommand(DRAMCommand), .DRAMCommandValid(DRAMCommandValid),
    .DRAMCommandReady(DRAMCommandReady), .Grant(Grant),
    .AddrTransfer(AddrTransfer), .PacketDone(PacketDone)
  );
  typedef struct {int len; logic [AW-1:0] base; logic [CW-1:0] cmd;} pkt_t;
  typedef struct {logic [2:0] g; logic [AW-1:0] a; logic [CW-1:0] c; logic d;} exp_t;
  pkt_t srcq[3][$];
  int beat[3];
  exp_t expq[$];
  int m_ptr = 0;
  int vectors = 0;
  int miscompares = 0;
  int bubble_pct = 0;
  int rdy_pct = 100;
  bit rdy_toggle = 0;
  int cyc = 0;
  function automatic int eff(input int len);
    return len == 0 ? 1 : len;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask
  task automatic add_pkt(input int r, input int len);
    pkt_t p;
    p.len = len;
    p.base = AW'($urandom);
    p.cmd = CW'($urandom);
    srcq[r].push_back(p);
  endtask
  // Expected transfer stream from the packet-level arbitration rules.
  task automatic plan(input bit saf);
    int h[3];
    int w;
    int r;
    int n;
    pkt_t p;
    exp_t e;
    for (int i = 0; i < 3; i++) h[i] = 0;
    while (h[0] < srcq[0].size() || h[1] < srcq[1].size() || h[2] < srcq[2].size()) begin
      w = -1;
      if (saf && h[1] < srcq[1].size()) w = 1;
      else for (int k = 0; k < 3; k++) begin
        r = (m_ptr + k) % 3;
        if (w < 0 && h[r] < srcq[r].size()) w = r;
      end
      p = srcq[w][h[w]];
      n = eff(p.len);
      for (int b = 0; b < n; b++) begin
        e.g = 3'(1 << w);
        e.a = p.base + AW'(b);
        e.c = p.cmd;
        e.d = (b == n - 1);
        expq.push_back(e);
      end
      h[w]++;
      m_ptr = (w + 1) % 3;
    end
  endtask
  task automatic drive();
    logic [AW-1:0] a[3];
    logic [CW-1:0] c[3];
    logic [LW-1:0] l[3];
    logic [2:0] v;
    for (int r = 0; r < 3; r++) begin
      if (srcq[r].size() > 0) begin
        a[r] = srcq[r][0].base + AW'(beat[r]);
        c[r] = srcq[r][0].cmd;
        l[r] = LW'(srcq[r][0].len);
        v[r] = !(Grant[r] && ($urandom_range(99) < 32'(bubble_pct)));
      end else begin
        a[r] = AW'($urandom);
        c[r] = CW'($urandom);
        l[r] = '0;
        v[r] = 1'b0;
      end
    end
    RDAddr = a[0]; RDCmd = c[0]; RDLen = l[0]; RDValid = v[0];
    WBAddr = a[1]; WBCmd = c[1]; WBLen = l[1]; WBValid = v[1];
    HDAddr = a[2]; HDCmd = c[2]; HDLen = l[2]; HDValid = v[2];
    DRAMCommandReady = rdy_toggle ? cyc[0] : ($urandom_range(99) < 32'(rdy_pct));
  endtask
  task automatic run_phase(input bit saf, input int rp, input bit tog, input int bp,
                           input int saf_raise, input int stop_after, output int n);
    int xfers;
    int w;
    logic x;
    logic [2:0] g;
    StashAlmostFull = saf;
    rdy_pct = rp;
    rdy_toggle = tog;
    bubble_pct = bp;
    plan(saf);
    n = 0;
    xfers = 0;
    drive();
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() > 0 || expq.size() > 0)
           && n < 20000 && (stop_after < 0 || xfers < stop_after)) begin
      @(negedge Clock);
      x = AddrTransfer;
      g = Grant;
      @(posedge Clock);
      #1;
      n++;
      cyc++;
      if (x && g != 3'b000) begin
        xfers++;
        w = g[0] ? 0 : g[1] ? 1 : 2;
        if (srcq[w].size() > 0) begin
          beat[w]++;
          if (beat[w] >= eff(srcq[w][0].len)) begin
            void'(srcq[w].pop_front());
            beat[w] = 0;
          end
        end
      end
      if (saf_raise >= 0 && xfers == saf_raise) StashAlmostFull = 1'b1;
      drive();
    end
    if (n >= 20000) begin
      vectors++;
      miscompares++;
      $display("FAIL phase_timeout: %0d beats still expected after %0d cycles", expq.size(), n);
      expq.delete();
      for (int r = 0; r < 3; r++) begin srcq[r].delete(); beat[r] = 0; end
    end
  endtask
  task automatic do_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    expq.delete();
    for (int r = 0; r < 3; r++) begin srcq[r].delete(); beat[r] = 0; end
    m_ptr = 0;
    drive();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask
  // Monitor: every transfer is matched against the head of the expected stream.
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        if (prev_done) begin
          vectors++;
          if (Grant != 3'b000 || DRAMCommandValid || AddrTransfer) begin
            miscompares++;
            $display("FAIL idle_bubble: grant=%b valid=%b xfer=%b, want grant=000 valid=0 xfer=0",
                     Grant, DRAMCommandValid, AddrTransfer);
          end
        end
        if (AddrTransfer) begin
          vectors++;
          if (expq.size() == 0) begin
            miscompares++;
            $display("FAIL beat: unexpected transfer grant=%b addr=%h, want none", Grant, DRAMAddr);
          end else begin
            e = expq.pop_front();
            if (Grant !== e.g || DRAMAddr !== e.a || DRAMCommand !== e.c || PacketDone !== e.d) begin
              miscompares++;
              $display("FAIL beat: got grant=%b addr=%h cmd=%h done=%b, want grant=%b addr=%h cmd=%h done=%b",
                       Grant, DRAMAddr, DRAMCommand, PacketDone, e.g, e.a, e.c, e.d);
            end
          end
        end
        prev_done = PacketDone;
      end else prev_done = 1'b0;
    end
  end
  initial begin
    int n;
    StashAlmostFull = 1'b0;
    for (int r = 0; r < 3; r++) beat[r] = 0;
    drive();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_grant", 32'(Grant), 0);
    chk("rst_ready", 32'({HDReady, WBReady, RDReady}), 0);
    chk("rst_cmd_valid", 32'(DRAMCommandValid), 0);
    chk("rst_xfer", 32'(AddrTransfer), 0);
    chk("rst_done", 32'(PacketDone), 0);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    // round-robin: RD, WB, HD, RD with one bubble cycle per packet
    add_pkt(0, 4); add_pkt(1, 4); add_pkt(2, 4); add_pkt(0, 4);
    run_phase(0, 100, 0, 0, -1, -1, n);
    chk("rr_cycles", 32'(n), 20);
    // almost-full stash promotes WB over RD
    do_reset();
    add_pkt(0, 3); add_pkt(1, 3);
    run_phase(1, 100, 0, 0, -1, -1, n);
    // stash filling during an RD packet must not preempt it
    do_reset();
    add_pkt(0, 6); add_pkt(1, 3);
    run_phase(0, 100, 0, 0, 2, -1, n);
    // backpressure and bubbles on a WB packet
    add_pkt(1, 5);
    run_phase(0, 0, 1, 40, -1, -1, n);
    // zero-length packet is one beat
    add_pkt(0, 0);
    run_phase(0, 100, 0, 0, -1, -1, n);
    chk("len0_cycles", 32'(n), 2);
    // maximum-length packet
    add_pkt(2, 1023);
    run_phase(0, 70, 0, 10, -1, -1, n);
    // reset in the middle of an 8-beat RD packet
    do_reset();
    add_pkt(0, 8);
    run_phase(0, 100, 0, 0, -1, 3, n);
    #1;
    Reset = 1'b0;
    #1;
    chk("midrst_grant", 32'(Grant), 0);
    chk("midrst_ready", 32'(RDReady), 0);
    chk("midrst_cmd_valid", 32'(DRAMCommandValid), 0);
    expq.delete();
    for (int r = 0; r < 3; r++) beat[r] = 0;
    m_ptr = 0;
    drive();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    chk("rearb_idle_grant", 32'(Grant), 0);
    run_phase(0, 100, 0, 0, -1, -1, n);
    chk("rearb_cycles", 32'(n), 9);
    // random mixes
    for (int ph = 0; ph < 10; ph++) begin
      for (int r = 0; r < 3; r++) begin
        int k;
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) add_pkt(r, $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 12));
      end
      run_phase(1'($urandom_range(0, 1)), $urandom_range(30, 100), 0, $urandom_range(0, 40), -1, -1, n);
    end
    repeat (3) @(posedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
